// File: rtl/mod_reduce21_c5.sv
// Reduces a 21-bit accumulator value modulo an 18-bit modulus using four restoring
// subtract steps (mod<<3 .. mod<<0), then holds the residue until the consumer takes it.
module mod_reduce21_c5 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [20:0] in_value,
  input  logic [17:0] modulus,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [17:0] out_residue,
  output logic        out_err,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [20:0] rem_q, rem_d;
  logic [17:0] mod_q, mod_d;
  logic [1:0]  k_q, k_d;
  logic [17:0] res_q, res_d;
  logic        err_q, err_d;

  logic [20:0] sub_op;
  logic [20:0] rem_step;

  // mod<<3 of an 18-bit value fits exactly in 21 bits, so nothing is lost here.
  always_comb begin
    sub_op   = {3'b000, mod_q} << k_q;
    rem_step = (rem_q >= sub_op) ? (rem_q - sub_op) : rem_q;
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    mod_d   = mod_q;
    k_d     = k_q;
    res_d   = res_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          rem_d = in_value;
          mod_d = modulus;
          k_d   = 2'd3;
          if (modulus[17]) begin
            state_d = SUB;
          end else begin
            state_d = DONE;
            res_d   = 18'd0;
            err_d   = 1'b1;
          end
        end
      end
      SUB: begin
        rem_d = rem_step;
        if (k_q == 2'd0) begin
          state_d = DONE;
          res_d   = rem_step[17:0];
          err_d   = 1'b0;
        end else begin
          k_d = k_q - 2'd1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q   <= 21'd0;
      mod_q   <= 18'd0;
      k_q     <= 2'd0;
      res_q   <= 18'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      mod_q   <= mod_d;
      k_q     <= k_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign out_valid   = (state_q == DONE);
  assign out_residue = res_q;
  assign out_err     = err_q;

endmodule

// File: tb/tb_mod_reduce21_c5.sv
// Randomized plus directed check of mod_reduce21_c5 against a transaction-level
// model: residue = value % modulus, fixed latency, result held until taken.
module tb_mod_reduce21_c5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [20:0] in_value = 21'd0;
  logic [17:0] modulus = 18'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [17:0] out_residue;
  logic        out_err;
  logic        busy;

  mod_reduce21_c5 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_value   (in_value),
    .modulus    (modulus),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_residue(out_residue),
    .out_err    (out_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;
  int n_acc  = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: one operand in flight, result after a fixed number of edges.
  bit          m_busy = 1'b0;
  bit          m_done = 1'b0;
  int          m_cnt  = 0;
  logic [17:0] m_res  = 18'd0;
  logic        m_err  = 1'b0;
  logic [17:0] m_mod  = 18'd0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_cnt  <= 0;
    end else if (!m_busy) begin
      if (in_valid) begin
        m_busy <= 1'b1;
        n_acc  <= n_acc + 1;
        m_mod  <= modulus;
        if (modulus[17]) begin
          m_cnt  <= 4;
          m_done <= 1'b0;
          m_res  <= 18'(int'(in_value) % int'(modulus));
          m_err  <= 1'b0;
        end else begin
          m_cnt  <= 0;
          m_done <= 1'b1;
          m_res  <= 18'd0;
          m_err  <= 1'b1;
        end
      end
    end else if (!m_done) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) m_done <= 1'b1;
    end else if (out_ready) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", 32'(in_ready), 32'(!m_busy));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("out_valid", 32'(out_valid), 32'(m_done));
      if (m_done) begin
        chk("residue", 32'(out_residue), 32'(m_res));
        chk("err", 32'(out_err), 32'(m_err));
        if (!out_err) chk("res_lt_mod", 32'(out_residue < m_mod), 32'd1);
      end
    end
  end

  task automatic op(input logic [20:0] v, input logic [17:0] m, input int stall,
                    output logic [17:0] res, output logic err, output int lat);
    @(negedge clk);
    in_valid  = 1'b1;
    in_value  = v;
    modulus   = m;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_value = 21'($urandom);
    modulus  = 18'($urandom);
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      in_value = 21'($urandom);
    end
    if (!out_valid) chk("op_timeout", 32'(out_valid), 32'd1);
    res = out_residue;
    err = out_err;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      #1;
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_res", 32'(out_residue), 32'(res));
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("drop_valid", 32'(out_valid), 32'd0);
    chk("back_idle", 32'(in_ready), 32'd1);
  endtask

  logic [17:0] r;
  logic        e;
  int          lat;
  int          cyc;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_residue", 32'(out_residue), 32'd0);
    chk("rst_err", 32'(out_err), 32'd0);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    op(21'h1FFFFF, 18'h3FFFF, 0, r, e, lat);
    chk("v1_res", 32'(r), 32'd7);
    chk("v1_err", 32'(e), 32'd0);
    chk("v1_lat", 32'(lat), 32'd5);

    op(21'h100000, 18'h20001, 0, r, e, lat);
    chk("v2_res", 32'(r), 32'd131065);

    op(21'd5, 18'h3FFFF, 0, r, e, lat);
    chk("v3a_res", 32'(r), 32'd5);
    op(21'h3FFFF, 18'h3FFFF, 0, r, e, lat);
    chk("v3b_res", 32'(r), 32'd0);

    op(21'h12345, 18'h0FFFF, 0, r, e, lat);
    chk("v4_err", 32'(e), 32'd1);
    chk("v4_res", 32'(r), 32'd0);
    chk("v4_lat", 32'(lat), 32'd1);

    op(21'h1FFFFF, 18'h3FFFF, 3, r, e, lat);
    chk("v5_res", 32'(r), 32'd7);

    op(21'h1E0000, 18'h20000, 0, r, e, lat);
    chk("m20000_res", 32'(r), 32'd0);

    // Reset lands in the second SUB cycle; the operand must vanish without output.
    @(negedge clk);
    in_valid = 1'b1;
    in_value = 21'h1FFFFF;
    modulus  = 18'h3FFFF;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("v6_out_valid", 32'(out_valid), 32'd0);
    chk("v6_busy", 32'(busy), 32'd0);
    chk("v6_in_ready", 32'(in_ready), 32'd1);
    chk("v6_residue", 32'(out_residue), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("v6_no_output", 32'(out_valid), 32'd0);
    end
    op(21'h40002, 18'h20001, 0, r, e, lat);
    chk("v6_res", 32'(r), 32'd0);

    n_acc = 0;
    cyc   = 0;
    while (n_acc < 10000 && cyc < 90000) begin
      @(negedge clk);
      cyc++;
      in_valid  = ($urandom_range(0, 5) != 0);
      in_value  = 21'($urandom);
      modulus   = {1'b1, 17'($urandom)};
      out_ready = ($urandom_range(0, 7) != 0);
    end
    if (n_acc < 10000) chk("random_budget", 32'(n_acc), 32'd10000);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (10) @(negedge clk);
    chk("drain_idle", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
